// File: rtl/aes_keygen_fsm.sv
// Word-serial AES-128 key-expansion controller: loads K0/KS, then sequences W4..W43 and parks in DONE.
// Optional `done` output is enabled by defining KEYGEN_DONE_OUT_EN.
module aes_keygen_fsm #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       EN,
  output logic       sel,
  output logic [3:0] Rcon_index,
  output logic       WR_EN_SR,
  output logic       LD_SR,
  output logic       WR_EN_KS,
  output logic       WR_EN_IN_REG,
  output logic       WR_EN_K0,
  output logic [3:0] index_KS,
  output logic [1:0] blk_no_KS
`ifdef KEYGEN_DONE_OUT_EN
  ,
  output logic       done
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_WRITE   = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [3:0] LP_LAST_RND = 4'(NUM_ROUNDS);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_rnd,   w_rnd_nxt;
  logic [1:0] r_blk,   w_blk_nxt;

  // reset_n is active-high despite its name
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state <= S_IDLE;
      r_rnd   <= 4'd0;
      r_blk   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_rnd   <= w_rnd_nxt;
      r_blk   <= w_blk_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rnd_nxt   = r_rnd;
    w_blk_nxt   = r_blk;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_LOAD;
        w_blk_nxt   = 2'd0;
      end
      S_LOAD: begin
        if (r_blk == 2'd3) begin
          w_state_nxt = S_COMPUTE;
          w_rnd_nxt   = 4'd1;
          w_blk_nxt   = 2'd0;
        end else begin
          w_blk_nxt   = r_blk + 2'd1;
        end
      end
      S_COMPUTE: w_state_nxt = S_WRITE;
      S_WRITE: begin
        if (r_blk != 2'd3) begin
          w_state_nxt = S_COMPUTE;
          w_blk_nxt   = r_blk + 2'd1;
        end else if (r_rnd < LP_LAST_RND) begin
          w_state_nxt = S_COMPUTE;
          w_rnd_nxt   = r_rnd + 4'd1;
          w_blk_nxt   = 2'd0;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: w_state_nxt = S_DONE;
      default: begin
        w_state_nxt = S_IDLE;
        w_rnd_nxt   = 4'd0;
        w_blk_nxt   = 2'd0;
      end
    endcase
  end

  always_comb begin
    EN           = 1'b0;
    sel          = 1'b0;
    Rcon_index   = 4'd0;
    WR_EN_SR     = 1'b0;
    LD_SR        = 1'b0;
    WR_EN_KS     = 1'b0;
    WR_EN_IN_REG = 1'b0;
    WR_EN_K0     = 1'b0;
    index_KS     = 4'd0;
    blk_no_KS    = 2'd0;
    case (r_state)
      S_LOAD: begin
        WR_EN_K0  = 1'b1;
        WR_EN_KS  = 1'b1;
        blk_no_KS = r_blk;
        LD_SR     = (r_blk == 2'd3);
      end
      S_COMPUTE: begin
        WR_EN_IN_REG = 1'b1;
        index_KS     = r_rnd;
        blk_no_KS    = r_blk;
        Rcon_index   = r_rnd;
        sel          = (r_blk == 2'd0);
        EN           = (r_blk == 2'd0);
      end
      S_WRITE: begin
        WR_EN_KS   = 1'b1;
        WR_EN_SR   = 1'b1;
        index_KS   = r_rnd;
        blk_no_KS  = r_blk;
        Rcon_index = r_rnd;
        sel        = (r_blk == 2'd0);
      end
      default: ;
    endcase
  end

`ifdef KEYGEN_DONE_OUT_EN
  assign done = (r_state == S_DONE);
`endif

endmodule

// File: tb/tb_aes_keygen_fsm.sv
// Scoreboard bench: stimulus pushes per-edge expected outputs from the edge-timing table; a negedge monitor compares.
module tb_aes_keygen_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       EN, sel, WR_EN_SR, LD_SR, WR_EN_KS, WR_EN_IN_REG, WR_EN_K0;
  logic [3:0] Rcon_index, index_KS;
  logic [1:0] blk_no_KS;
`ifdef KEYGEN_DONE_OUT_EN
  logic       done;
`endif

  aes_keygen_fsm #(.NUM_ROUNDS(10)) dut (
    .clk(clk), .reset_n(reset_n), .EN(EN), .sel(sel), .Rcon_index(Rcon_index),
    .WR_EN_SR(WR_EN_SR), .LD_SR(LD_SR), .WR_EN_KS(WR_EN_KS),
    .WR_EN_IN_REG(WR_EN_IN_REG), .WR_EN_K0(WR_EN_K0),
    .index_KS(index_KS), .blk_no_KS(blk_no_KS)
`ifdef KEYGEN_DONE_OUT_EN
    , .done(done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          n;       // edge number after release, -1 while in reset
    logic [16:0] v;
    logic        dn;
    int          ks_exp;  // expected cumulative WR_EN_KS count, -1 = no check
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ks_cnt = 0;

  // {EN, sel, Rcon, SR, LD, KS, IN_REG, K0, index, blk}
  function automatic logic [16:0] pack(logic en, logic sl, logic [3:0] rc, logic sr, logic ld,
                                       logic ks, logic ir, logic k0, logic [3:0] ix, logic [1:0] bk);
    return {en, sl, rc, sr, ld, ks, ir, k0, ix, bk};
  endfunction

  function automatic logic [16:0] exp_vec(int n);
    int k, r, w;
    if (n >= 1 && n <= 4)
      return pack(0, 0, 4'd0, 0, (n == 4), 1, 0, 1, 4'd0, 2'(n - 1));
    if (n >= 5 && n <= 84) begin
      k = n - 5; r = k / 8 + 1; w = (k % 8) / 2;
      if (k % 2 == 0)
        return pack((w == 0), (w == 0), 4'(r), 0, 0, 0, 1, 0, 4'(r), 2'(w));
      return pack(0, (w == 0), 4'(r), 1, 0, 1, 0, 0, 4'(r), 2'(w));
    end
    return 17'd0;
  endfunction

  task automatic step(int n, int ks_exp);
    exp_t e;
    @(posedge clk); #1;
    e.n = n; e.v = exp_vec(n); e.dn = (n >= 85); e.ks_exp = ks_exp;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [16:0] got;
    if (WR_EN_KS === 1'b1) ks_cnt++;
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = {EN, sel, Rcon_index, WR_EN_SR, LD_SR, WR_EN_KS, WR_EN_IN_REG, WR_EN_K0, index_KS, blk_no_KS};
      checks++;
      if (got !== e.v) begin
        errors++;
        $display("FAIL outputs edge %0d: got %h expected %h", e.n, got, e.v);
      end
`ifdef KEYGEN_DONE_OUT_EN
      checks++;
      if (done !== e.dn) begin
        errors++;
        $display("FAIL done edge %0d: got %b expected %b", e.n, done, e.dn);
      end
`endif
      if (e.ks_exp >= 0) begin
        checks++;
        if (ks_cnt != e.ks_exp) begin
          errors++;
          $display("FAIL ks_count edge %0d: got %0d expected %0d", e.n, ks_cnt, e.ks_exp);
        end
      end
    end
  end

  initial begin
    int guard;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(-1, (i == 2) ? 0 : -1);
    reset_n = 1'b0;
    // first full generation, long tail to confirm DONE is terminal
    for (int n = 1; n <= 1000; n++)
      step(n, (n == 83) ? 43 : (n == 84 || n == 1000) ? 44 : -1);
    // restart mid-generation: reset sampled on edge 40
    reset_n = 1'b1;
    step(-1, -1);
    reset_n = 1'b0;
    for (int n = 1; n <= 39; n++) step(n, -1);
    reset_n = 1'b1;
    step(-1, -1);
    reset_n = 1'b0;
    for (int n = 1; n <= 12; n++) step(n, -1);
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk); guard++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
